// File: rtl/smart_home_ctrl_p.sv
// rtl/smart_home_ctrl_p.sv - priority-driven smart-home controller FSM
// Optional temperature hysteresis band enabled by macro SMART_HOME_HYST_EN.
module smart_home_ctrl_p #(
  parameter int NW        = 4,
  parameter int TW        = 7,
  parameter int T_LOW     = 50,
  parameter int T_HIGH    = 70,
  parameter int HYST      = 2,
  parameter int DOOR_HOLD = 8,
  parameter int ALARM_CLR = 4
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          SFD,
  input  logic          SRD,
  input  logic          SFA,
  input  logic [NW-1:0] SW,
  input  logic [TW-1:0] ST,
  output logic          fdoor,
  output logic          rdoor,
  output logic          winbuzz,
  output logic          alarmbuzz,
  output logic          heater,
  output logic          cooler,
  output logic [2:0]    win_idx,
  output logic [2:0]    display
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FDOOR  = 3'd1;
  localparam logic [2:0] S_RDOOR  = 3'd2;
  localparam logic [2:0] S_WINDOW = 3'd3;
  localparam logic [2:0] S_ALARM  = 3'd4;
  localparam logic [2:0] S_HEAT   = 3'd5;
  localparam logic [2:0] S_COOL   = 3'd6;

`ifdef SMART_HOME_HYST_EN
  localparam int LP_BAND = HYST;
`else
  localparam int LP_BAND = HYST * 0;
`endif

  // One extra bit so threshold arithmetic never wraps against ST.
  localparam logic [TW:0] LP_HEAT_IN   = (TW+1)'(T_LOW);
  localparam logic [TW:0] LP_HEAT_HOLD = (TW+1)'(T_LOW + LP_BAND);
  localparam logic [TW:0] LP_COOL_IN   = (TW+1)'(T_HIGH);
  localparam logic [TW:0] LP_COOL_HOLD = (TW+1)'(T_HIGH - LP_BAND);
  localparam logic [7:0]  LP_HOLD      = 8'(DOOR_HOLD);
  localparam logic [7:0]  LP_ACLR      = 8'(ALARM_CLR);

  logic [2:0] r_state;
  logic [7:0] r_hold;
  logic [7:0] r_aclr;
  logic       r_fdoor, r_rdoor, r_winbuzz, r_alarmbuzz, r_heater, r_cooler;
  logic [2:0] r_win_idx;

  logic [2:0]  w_next;
  logic [7:0]  w_hold_nxt;
  logic [7:0]  w_aclr_nxt;
  logic [TW:0] w_st;
  logic [2:0]  w_low;
  logic        w_fdoor, w_rdoor, w_winbuzz, w_alarmbuzz, w_heater, w_cooler;
  logic [2:0]  w_win_idx;

  assign w_st = {1'b0, ST};

  always_comb begin
    w_low = 3'd0;
    for (int i = NW - 1; i >= 0; i--) begin
      if (SW[i]) w_low = 3'(i);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state     <= S_IDLE;
      r_hold      <= 8'd0;
      r_aclr      <= 8'd0;
      r_fdoor     <= 1'b0;
      r_rdoor     <= 1'b0;
      r_winbuzz   <= 1'b0;
      r_alarmbuzz <= 1'b0;
      r_heater    <= 1'b0;
      r_cooler    <= 1'b0;
      r_win_idx   <= 3'd0;
    end else begin
      r_state     <= w_next;
      r_hold      <= w_hold_nxt;
      r_aclr      <= w_aclr_nxt;
      r_fdoor     <= w_fdoor;
      r_rdoor     <= w_rdoor;
      r_winbuzz   <= w_winbuzz;
      r_alarmbuzz <= w_alarmbuzz;
      r_heater    <= w_heater;
      r_cooler    <= w_cooler;
      r_win_idx   <= w_win_idx;
    end
  end

  // Hold terms only apply while already in HEAT/COOL, so any return from a
  // higher-priority state sees the entry thresholds alone.
  always_comb begin
    w_next     = S_IDLE;
    w_hold_nxt = 8'd0;
    w_aclr_nxt = 8'd0;
    if (r_state > S_COOL) begin
      w_next = S_IDLE;
    end else if (SFA) begin
      w_next = S_ALARM;
    end else if (r_state == S_ALARM && (r_aclr + 8'd1) < LP_ACLR) begin
      w_next     = S_ALARM;
      w_aclr_nxt = r_aclr + 8'd1;
    end else if (SFD) begin
      w_next     = S_FDOOR;
      w_hold_nxt = LP_HOLD;
    end else if (r_state == S_FDOOR && r_hold != 8'd0) begin
      w_next     = S_FDOOR;
      w_hold_nxt = r_hold - 8'd1;
    end else if (SRD) begin
      w_next = S_RDOOR;
    end else if (|SW) begin
      w_next = S_WINDOW;
    end else if (w_st < LP_HEAT_IN || (r_state == S_HEAT && w_st < LP_HEAT_HOLD)) begin
      w_next = S_HEAT;
    end else if (w_st > LP_COOL_IN || (r_state == S_COOL && w_st > LP_COOL_HOLD)) begin
      w_next = S_COOL;
    end
  end

  always_comb begin
    w_fdoor     = (w_next == S_FDOOR);
    w_rdoor     = (w_next == S_RDOOR);
    w_winbuzz   = (w_next == S_WINDOW);
    w_alarmbuzz = (w_next == S_ALARM);
    w_heater    = (w_next == S_HEAT);
    w_cooler    = (w_next == S_COOL);
    w_win_idx   = (w_next == S_WINDOW) ? w_low : 3'd0;
  end

  assign fdoor     = r_fdoor;
  assign rdoor     = r_rdoor;
  assign winbuzz   = r_winbuzz;
  assign alarmbuzz = r_alarmbuzz;
  assign heater    = r_heater;
  assign cooler    = r_cooler;
  assign win_idx   = r_win_idx;
  assign display   = r_state;

endmodule

// File: tb/tb_smart_home_ctrl_p.sv
// tb/tb_smart_home_ctrl_p.sv - scoreboard testbench for smart_home_ctrl_p
`timescale 1ns/1ps
module tb_smart_home_ctrl_p;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FDOOR  = 3'd1;
  localparam logic [2:0] S_RDOOR  = 3'd2;
  localparam logic [2:0] S_WINDOW = 3'd3;
  localparam logic [2:0] S_ALARM  = 3'd4;
  localparam logic [2:0] S_HEAT   = 3'd5;
  localparam logic [2:0] S_COOL   = 3'd6;

`ifdef SMART_HOME_HYST_EN
  localparam logic [2:0] S_HB = S_HEAT;
  localparam logic [2:0] S_CB = S_COOL;
`else
  localparam logic [2:0] S_HB = S_IDLE;
  localparam logic [2:0] S_CB = S_IDLE;
`endif

  typedef struct packed {
    logic       rn;
    logic       a;
    logic       d;
    logic       r;
    logic [3:0] w;
    logic [6:0] t;
    logic [2:0] s;
    logic [2:0] idx;
  } step_t;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       SFD = 1'b0;
  logic       SRD = 1'b0;
  logic       SFA = 1'b0;
  logic [3:0] SW  = 4'h0;
  logic [6:0] ST  = 7'd60;
  logic       fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler;
  logic [2:0] win_idx, display;

  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] exp_q[$];

  smart_home_ctrl_p dut (
    .Clk(Clk), .Rst(Rst), .SFD(SFD), .SRD(SRD), .SFA(SFA), .SW(SW), .ST(ST),
    .fdoor(fdoor), .rdoor(rdoor), .winbuzz(winbuzz), .alarmbuzz(alarmbuzz),
    .heater(heater), .cooler(cooler), .win_idx(win_idx), .display(display)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic step_t mk_step(input logic rn, input logic a, input logic d, input logic r,
                                    input logic [3:0] w, input logic [6:0] t,
                                    input logic [2:0] s, input logic [2:0] idx);
    step_t x;
    x.rn = rn; x.a = a; x.d = d; x.r = r; x.w = w; x.t = t; x.s = s; x.idx = idx;
    return x;
  endfunction

  function automatic logic [11:0] mk_exp(input logic [2:0] s, input logic [2:0] idx);
    return {s, s == S_FDOOR, s == S_RDOOR, s == S_WINDOW, s == S_ALARM,
            s == S_HEAT, s == S_COOL, idx};
  endfunction

  function automatic logic [11:0] obs();
    return {display, fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler, win_idx};
  endfunction

  task automatic send(input step_t s);
    exp_q.push_back(mk_exp(s.s, s.idx));
    Rst = s.rn; SFA = s.a; SFD = s.d; SRD = s.r; SW = s.w; ST = s.t;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    step_t q[$];
    logic [11:0] e, g;
    q.push_back(mk_step(1'b0, 1'b1, 1'b1, 1'b1, 4'hf, 7'd10, S_IDLE, 3'd0));
    q.push_back(mk_step(1'b0, 1'b1, 1'b1, 1'b1, 4'hf, 7'd100, S_IDLE, 3'd0));
    foreach (q[i]) begin
      send(q[i]);
      e = exp_q.pop_front();
      g = obs();
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %h expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_door_hold();
    step_t q[$];
    logic [11:0] e, g;
    int hi = 0;
    for (int i = 0; i < 13; i++)
      q.push_back(mk_step(1'b1, 1'b0, (i < 3), 1'b0, 4'h0, 7'd60,
                          (i < 11) ? S_FDOOR : S_IDLE, 3'd0));
    foreach (q[i]) begin
      send(q[i]);
      e = exp_q.pop_front();
      g = obs();
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL door_hold[%0d]: got %h expected %h", i, g, e);
      end
      if (fdoor === 1'b1) hi++;
    end
    n_checks++;
    if (hi != 11) begin
      n_fail++;
      $display("FAIL door_hold_len: got %0d cycles expected 11", hi);
    end
  endtask

  task automatic test_priority();
    step_t q[$];
    logic [11:0] e, g;
    q.push_back(mk_step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0110, 7'd60, S_ALARM, 3'd0));
    for (int i = 0; i < 3; i++)
      q.push_back(mk_step(1'b1, 1'b0, 1'b1, 1'b0, 4'b0110, 7'd60, S_ALARM, 3'd0));
    q.push_back(mk_step(1'b1, 1'b0, 1'b1, 1'b0, 4'b0110, 7'd60, S_FDOOR, 3'd0));
    for (int i = 0; i < 8; i++)
      q.push_back(mk_step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0110, 7'd60, S_FDOOR, 3'd0));
    q.push_back(mk_step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0110, 7'd60, S_WINDOW, 3'd1));
    q.push_back(mk_step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 7'd60, S_WINDOW, 3'd2));
    q.push_back(mk_step(1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, 7'd60, S_WINDOW, 3'd3));
    q.push_back(mk_step(1'b1, 1'b0, 1'b0, 1'b0, 4'b1001, 7'd60, S_WINDOW, 3'd0));
    q.push_back(mk_step(1'b1, 1'b0, 1'b0, 1'b1, 4'b1111, 7'd10, S_RDOOR, 3'd0));
    q.push_back(mk_step(1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 7'd60, S_RDOOR, 3'd0));
    q.push_back(mk_step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 7'd60, S_IDLE, 3'd0));
    foreach (q[i]) begin
      send(q[i]);
      e = exp_q.pop_front();
      g = obs();
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL priority[%0d]: got %h expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_alarm_restart();
    step_t q[$];
    logic [11:0] e, g;
    logic [8:0] pat;
    pat = 9'b100010000;
    for (int i = 0; i < 9; i++)
      q.push_back(mk_step(1'b1, pat[8-i], 1'b0, 1'b0, 4'h0, 7'd60,
                          (i < 8) ? S_ALARM : S_IDLE, 3'd0));
    foreach (q[i]) begin
      send(q[i]);
      e = exp_q.pop_front();
      g = obs();
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL alarm_restart[%0d]: got %h expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_hysteresis();
    step_t q[$];
    logic [11:0] e, g;
    q.push_back(mk_step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 7'd49, S_HEAT, 3'd0));
    q.push_back(mk_step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 7'd50, S_HB,   3'd0));
    q.push_back(mk_step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 7'd51, S_HB,   3'd0));
    q.push_back(mk_step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 7'd52, S_IDLE, 3'd0));
    q.push_back(mk_step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 7'd50, S_IDLE, 3'd0));
    q.push_back(mk_step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 7'd70, S_IDLE, 3'd0));
    q.push_back(mk_step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 7'd71, S_COOL, 3'd0));
    q.push_back(mk_step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 7'd69, S_CB,   3'd0));
    q.push_back(mk_step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 7'd68, S_IDLE, 3'd0));
    q.push_back(mk_step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 7'd49, S_HEAT, 3'd0));
    q.push_back(mk_step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 7'd51, S_HB,   3'd0));
    q.push_back(mk_step(1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 7'd51, S_RDOOR, 3'd0));
    q.push_back(mk_step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 7'd51, S_IDLE, 3'd0));
    q.push_back(mk_step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 7'd60, S_IDLE, 3'd0));
    foreach (q[i]) begin
      send(q[i]);
      e = exp_q.pop_front();
      g = obs();
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL hysteresis[%0d]: got %h expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    step_t q[$];
    logic [11:0] e, g;
    q.push_back(mk_step(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 7'd60, S_FDOOR, 3'd0));
    q.push_back(mk_step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 7'd60, S_FDOOR, 3'd0));
    q.push_back(mk_step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 7'd60, S_IDLE,  3'd0));
    q.push_back(mk_step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 7'd60, S_ALARM, 3'd0));
    for (int i = 0; i < 3; i++)
      q.push_back(mk_step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 7'd60, S_ALARM, 3'd0));
    q.push_back(mk_step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 7'd60, S_IDLE, 3'd0));
    foreach (q[i]) begin
      send(q[i]);
      e = exp_q.pop_front();
      g = obs();
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL reset_mid[%0d]: got %h expected %h", i, g, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_door_hold();
    test_priority();
    test_alarm_restart();
    test_hysteresis();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
